// File: rtl/sparc_pkg.sv
// Shared definitions for the SPARC multiply/divide unit: operation
// encodings, the sequencer state type and the divide saturation values.
package sparc_pkg;

    // Operation encodings on the op input.
    localparam logic [1:0] MD_UMUL = 2'b00;
    localparam logic [1:0] MD_SMUL = 2'b01;
    localparam logic [1:0] MD_UDIV = 2'b10;
    localparam logic [1:0] MD_SDIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_t;

    // Quotient saturation values.
    localparam logic [31:0] SAT_U32 = 32'hFFFF_FFFF;
    localparam logic [31:0] SAT_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] SAT_NEG = 32'h8000_0000;

endpackage

// File: rtl/sign_mag.sv
// Combinational two's-complement conditional negate. With negate tied to
// the operand sign bit it yields the magnitude; with negate tied to a
// desired result sign it applies sign correction.
//   value  : input word
//   negate : 1 -> result = -value, 0 -> result = value
//   result : output word
module sign_mag #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/sparc_muldiv_unit.sv
// Iterative SPARC multiply/divide unit (UMUL/SMUL/UDIV/SDIV) with the Y
// register. A start in IDLE runs 32 shift-add or restoring-divide
// iterations on operand magnitudes, then a sign/saturation fix cycle,
// then a done pulse. Divide by zero completes after one cycle with a
// div_zero pulse and leaves result, Y and flags untouched.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, op        : request and operation (sampled only in IDLE)
//   rs1, op2         : source operands
//   y_wr, y_wdata    : Y write, honoured only in IDLE without start
//   busy, done       : handshake; done is a one-cycle pulse
//   result, y_out    : completed result, current Y
//   icc_n/z/v/c      : condition codes of the last completed operation
//   div_zero         : one-cycle trap request with done
module sparc_muldiv_unit
    import sparc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] op2,
    input  logic             y_wr,
    input  logic [WIDTH-1:0] y_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] y_out,
    output logic             icc_n,
    output logic             icc_z,
    output logic             icc_v,
    output logic             icc_c,
    output logic             div_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    md_state_t         state, state_nxt;
    logic [CW-1:0]     cnt;
    logic [1:0]        op_q;
    logic              dz_q;

    // Datapath state: shared accumulator, multiplicand/divisor magnitude,
    // result sign and overflow indication.
    logic [DW-1:0]     acc;
    logic [WIDTH-1:0]  dsr;
    logic              neg_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  rs1_mag, op2_mag;
    logic [DW-1:0]     dvd_mag, acc_fix, acc_iter;
    logic              pre_ovf;
    logic [WIDTH:0]    mul_sum, div_rem, div_diff;
    logic [WIDTH:0]    div_fix;

    // Returns {overflow, quotient} for a divide given the unsigned quotient
    // magnitude q and its negation q_neg.
    function automatic logic [WIDTH:0] div_saturate(
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] q_neg,
        input logic             ovf,
        input logic             sgn,
        input logic             neg
    );
        if (!sgn)
            return ovf ? {1'b1, SAT_U32} : {1'b0, q};
        if (neg) begin
            if (ovf || (q > SAT_NEG))
                return {1'b1, SAT_NEG};
            return {1'b0, q_neg};
        end
        if (ovf || (q > SAT_POS))
            return {1'b1, SAT_POS};
        return {1'b0, q};
    endfunction

    sign_mag #(.WIDTH(WIDTH)) u_rs1_mag (
        .value  (rs1),
        .negate ((op == MD_SMUL) && rs1[WIDTH-1]),
        .result (rs1_mag)
    );

    sign_mag #(.WIDTH(WIDTH)) u_op2_mag (
        .value  (op2),
        .negate (op[0] && op2[WIDTH-1]),
        .result (op2_mag)
    );

    // The 64-bit dividend {Y, rs1} is signed by Y's top bit.
    sign_mag #(.WIDTH(DW)) u_dvd_mag (
        .value  ({y_out, rs1}),
        .negate ((op == MD_SDIV) && y_out[WIDTH-1]),
        .result (dvd_mag)
    );

    sign_mag #(.WIDTH(DW)) u_res_fix (
        .value  (acc),
        .negate (neg_q),
        .result (acc_fix)
    );

    // A quotient that cannot fit in 32 bits is detected before iterating;
    // the iterations still run so latency does not depend on the data.
    assign pre_ovf = (dvd_mag[DW-1:WIDTH] >= op2_mag);

    // Multiply: acc = {partial product high, multiplier bits still to use}.
    // Divide:   acc = {partial remainder, dividend bits / quotient bits}.
    always_comb begin
        mul_sum  = {1'b0, acc[DW-1:WIDTH]} + (acc[0] ? {1'b0, dsr} : '0);
        div_rem  = acc[DW-1:WIDTH-1];
        div_diff = div_rem - {1'b0, dsr};
        if (!op_q[1])
            acc_iter = {mul_sum, acc[WIDTH-1:1]};
        else if (div_diff[WIDTH])
            acc_iter = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            acc_iter = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    assign div_fix = div_saturate(acc[WIDTH-1:0], acc_fix[WIDTH-1:0],
                                  ovf_q, op_q[0], neg_q);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (op[1] && (op2 == '0)) ? DONE : CALC;
            CALC: if (cnt == '0) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign icc_c = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= MD_UMUL;
            dz_q     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            result   <= '0;
            y_out    <= '0;
            icc_n    <= 1'b0;
            icc_z    <= 1'b0;
            icc_v    <= 1'b0;
        end else begin
            state    <= state_nxt;
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        cnt  <= CW'(WIDTH - 1);
                        dz_q <= op[1] && (op2 == '0);
                    end else if (y_wr) begin
                        y_out <= y_wdata;
                    end
                end
                CALC: cnt <= cnt - CW'(1);
                DONE: begin
                    done     <= 1'b1;
                    div_zero <= dz_q;
                    if (!dz_q) begin
                        result <= acc[WIDTH-1:0];
                        if (!op_q[1])
                            y_out <= acc[DW-1:WIDTH];
                        icc_n <= acc[WIDTH-1];
                        icc_z <= (acc[WIDTH-1:0] == '0);
                        icc_v <= ovf_q;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    dsr   <= op2_mag;
                    ovf_q <= op[1] && pre_ovf;
                    if (op[1]) begin
                        acc   <= dvd_mag;
                        neg_q <= op[0] && (y_out[WIDTH-1] ^ op2[WIDTH-1]);
                    end else begin
                        acc   <= {{WIDTH{1'b0}}, rs1_mag};
                        neg_q <= op[0] && (rs1[WIDTH-1] ^ op2[WIDTH-1]);
                    end
                end
            end
            CALC: acc <= acc_iter;
            FIX: begin
                if (op_q[1]) begin
                    acc   <= {acc[DW-1:WIDTH], div_fix[WIDTH-1:0]};
                    ovf_q <= div_fix[WIDTH];
                end else begin
                    acc   <= acc_fix;
                    ovf_q <= 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sparc_muldiv_unit.sv
module tb_sparc_muldiv_unit;
    import sparc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1, op2;
    logic        y_wr;
    logic [31:0] y_wdata;
    logic        busy, done;
    logic [31:0] result, y_out;
    logic        icc_n, icc_z, icc_v, icc_c;
    logic        div_zero;

    sparc_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op       (op),
        .rs1      (rs1),
        .op2      (op2),
        .y_wr     (y_wr),
        .y_wdata  (y_wdata),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .y_out    (y_out),
        .icc_n    (icc_n),
        .icc_z    (icc_z),
        .icc_v    (icc_v),
        .icc_c    (icc_c),
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [31:0] y;
        logic [3:0]  icc;   // {n, z, v, c}
        logic        dz;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    int total  = 0;
    int passes = 0;

    // Reference architectural state of the unit.
    logic [31:0] m_y   = '0;
    logic [31:0] m_res = '0;
    logic [3:0]  m_icc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Computes the expected completion with plain 64-bit arithmetic and
    // pushes it to the scoreboard.
    task automatic push_expected(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [63:0] p;
        logic [63:0] uq;
        longint      sq;
        logic        v;
        e.dz  = 1'b0;
        e.lat = 34;
        v     = 1'b0;
        case (o)
            MD_UMUL: begin
                p     = {32'b0, a} * {32'b0, b};
                m_res = p[31:0];
                m_y   = p[63:32];
            end
            MD_SMUL: begin
                p     = 64'(longint'($signed(a)) * longint'($signed(b)));
                m_res = p[31:0];
                m_y   = p[63:32];
            end
            MD_UDIV: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1; e.lat = 1;
                end else begin
                    uq = {m_y, a} / {32'b0, b};
                    if (uq > 64'hFFFF_FFFF) begin
                        m_res = 32'hFFFF_FFFF; v = 1'b1;
                    end else begin
                        m_res = uq[31:0];
                    end
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1; e.lat = 1;
                end else begin
                    sq = longint'({m_y, a}) / longint'($signed(b));
                    if (sq > 64'sd2147483647) begin
                        m_res = 32'h7FFF_FFFF; v = 1'b1;
                    end else if (sq < -64'sd2147483648) begin
                        m_res = 32'h8000_0000; v = 1'b1;
                    end else begin
                        m_res = sq[31:0];
                    end
                end
            end
        endcase
        if (!e.dz)
            m_icc = {m_res[31], (m_res == 32'd0), v, 1'b0};
        e.res = m_res;
        e.y   = m_y;
        e.icc = m_icc;
        exp_q.push_back(e);
    endtask

    // mode: 0 plain, 1 extra start while busy, 2 y_wr while busy,
    // 3 y_wr together with start. Called and returns at a falling edge;
    // returns at the edge where done is observed.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int mode, input string tag);
        exp_t e;
        int   lat;
        push_expected(o, a, b);
        start = 1'b1; op = o; rs1 = a; op2 = b;
        y_wr = (mode == 3); y_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; y_wr = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (mode == 1 && lat == 5) begin
                start = 1'b1; op2 = 32'd3;
            end else if (mode == 2 && lat == 5) begin
                y_wr = 1'b1;
            end else begin
                start = 1'b0; y_wr = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0; y_wr = 1'b0;
        e = exp_q.pop_front();
        chk({tag, "_lat"},    lat, e.lat);
        chk({tag, "_result"}, result, e.res);
        chk({tag, "_y"},      y_out, e.y);
        chk({tag, "_icc"},    {28'b0, icc_n, icc_z, icc_v, icc_c}, {28'b0, e.icc});
        chk({tag, "_dz"},     {31'b0, div_zero}, {31'b0, e.dz});
        chk({tag, "_idle"},   {31'b0, busy}, 32'd0);
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        chk({tag, "_done_pulse"}, {30'b0, done, div_zero}, 32'd0);
    endtask

    task automatic write_y(input logic [31:0] d);
        y_wr = 1'b1; y_wdata = d;
        @(negedge clk);
        y_wr = 1'b0;
        m_y = d;
        chk("wry", y_out, d);
    endtask

    task automatic count_done(input int cycles, input string tag);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        chk(tag, n, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = MD_UMUL; rs1 = '0; op2 = '0;
        y_wr = 1'b0; y_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ctrl",   {29'b0, busy, done, div_zero}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_y",      y_out, 32'd0);
        chk("rst_icc",    {28'b0, icc_n, icc_z, icc_v, icc_c}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(MD_UMUL, 32'hFFFF_FFFF, 32'd2, 0, "umul");
        chk("umul_plan_result", result, 32'hFFFF_FFFE);
        chk("umul_plan_y", y_out, 32'h0000_0001);
        idle_check("umul");
        run_op(MD_SMUL, 32'hFFFF_FFFD, 32'd7, 0, "smul");
        chk("smul_plan_result", result, 32'hFFFF_FFEB);
        idle_check("smul");
        write_y(32'd0);
        run_op(MD_UDIV, 32'd100, 32'd7, 0, "udiv");
        chk("udiv_plan_result", result, 32'd14);
        idle_check("udiv");
        write_y(32'hFFFF_FFFF);
        run_op(MD_SDIV, 32'hFFFF_FF9C, 32'd7, 0, "sdiv_neg");
        chk("sdiv_plan_result", result, 32'hFFFF_FFF2);
        idle_check("sdiv_neg");
        write_y(32'd5);
        run_op(MD_UDIV, 32'd0, 32'd5, 0, "udiv_ovf");
        idle_check("udiv_ovf");
        run_op(MD_UDIV, 32'd1234, 32'd0, 0, "udiv_zero");
        idle_check("udiv_zero");
        run_op(MD_SDIV, 32'd1234, 32'd0, 0, "sdiv_zero");
        idle_check("sdiv_zero");
        write_y(32'd0);
        run_op(MD_SDIV, 32'h8000_0000, 32'd1, 0, "sdiv_pos_sat");
        idle_check("sdiv_pos_sat");
        write_y(32'hFFFF_FFFF);
        run_op(MD_SDIV, 32'h8000_0000, 32'd1, 0, "sdiv_min");
        // Issued in the cycle done is high.
        run_op(MD_SDIV, 32'd0, 32'd1, 0, "sdiv_neg_sat");
        idle_check("sdiv_neg_sat");
        write_y(32'd0);
        run_op(MD_SDIV, 32'd100, 32'hFFFF_FFF9, 0, "sdiv_negdivisor");
        idle_check("sdiv_negdivisor");
        run_op(MD_UMUL, 32'd3, 32'd5, 1, "start_busy");
        count_done(40, "start_busy_single_done");
        run_op(MD_UDIV, 32'd1000, 32'd10, 2, "ywr_busy");
        idle_check("ywr_busy");
        run_op(MD_UDIV, 32'd50, 32'd5, 3, "start_ywr");
        idle_check("start_ywr");

        write_y(32'h1234_5678);
        start = 1'b1; op = MD_SMUL; rs1 = 32'd5; op2 = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy",   {30'b0, busy, done}, 32'd0);
        chk("midrst_y",      y_out, 32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_icc",    {28'b0, icc_n, icc_z, icc_v, icc_c}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_y = '0; m_res = '0; m_icc = '0;
        count_done(40, "midrst_no_done");

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/sparc_muldiv_unit.md
# sparc_muldiv_unit

Iterative multiply/divide execution unit for the SPARC integer pipeline. Sits directly downstream of the source-operand-2 handler: consumes rs1 and the selected operand-2 word N. Executes UMUL/SMUL/UDIV/SDIV with the architectural Y register. Stalls the pipeline through a start/busy/done handshake for a fixed multi-cycle latency.

## Interface
- WIDTH, 32, operand and result width; only 32 is supported.
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request; sampled only when idle.
- op  in  2  operation: 00 UMUL, 01 SMUL, 10 UDIV, 11 SDIV.
- rs1  in  32  first source operand.
- op2  in  32  operand 2 from the source-operand handler.
- y_wr  in  1  write Y (WRY); honoured only when idle and start=0.
- y_wdata  in  32  Y write data.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  32  product low word or quotient; held until the next completion.
- y_out  out  32  current Y register.
- icc_n, icc_z, icc_v, icc_c  out  1 each  condition codes for the completed operation; held with result.
- div_zero  out  1  one-cycle pulse with done on a divide by zero (trap request).

## Operation
- FSM states: IDLE, CALC, FIX, DONE.
- IDLE, start=1: latch op, operands and Y, then go to CALC; iteration counter = 31.
- Exception: a divide op with op2==0 goes to DONE with div_zero set.
- CALC: one iteration per cycle; counter decrements; go to FIX when counter is 0.
- FIX: sign correction and overflow saturation, then DONE.
- DONE: pulse done, then return to IDLE.
- Multiply, shift-add over magnitudes:
  - SMUL negates the 64-bit product when the operand signs differ.
  - result = product[31:0]; Y = product[63:32].
- Divide, restoring division of 64-bit dividend {Y,rs1} by op2:
  - SDIV uses magnitudes and truncates toward zero.
  - Y is never modified by a divide.
- Overflow is checked pre-iteration: dividend magnitude[63:32] >= divisor magnitude.
  - Overflow still spends the full CALC time; latency is constant.
- Overflow results:
  - UDIV overflow: result = 0xFFFFFFFF, V=1.
  - SDIV positive quotient above 0x7FFFFFFF: result 0x7FFFFFFF, V=1.
  - SDIV negative quotient magnitude above 0x80000000: result 0x80000000, V=1.
- Flags: N=result[31], Z=(result==0), C=0. V=0 for multiply and for a non-overflowing divide.
- Divide by zero: result, Y and flags unchanged; done=1 and div_zero=1.
- start while busy: ignored.
- start and y_wr together in IDLE: start wins, Y write dropped.
- y_wr while busy: dropped.
- Reset values: busy 0, done 0, div_zero 0, result 0, y_out 0, all icc 0, state IDLE.

## Timing
- start sampled at edge E0; busy is high from after E0.
- Normal op: CALC occupies edges E1–E32, FIX at E33, DONE at E34.
  - done is high for exactly one cycle after E34; busy falls at the same edge.
  - Start-to-done latency: 34 cycles.
- Divide by zero: done and div_zero high for one cycle after E1; latency 1.
- result, Y and icc update at the edge that raises done.
- A new start is accepted in the cycle done is high, because the FSM is already in IDLE after that edge.
- rst_n low mid-operation: immediately abort, all outputs to reset values, no done pulse.

## Structure
- Shared package sparc_pkg holds:
  - op encodings MD_UMUL, MD_SMUL, MD_UDIV, MD_SDIV;
  - the FSM state typedef;
  - saturation constants 0xFFFFFFFF, 0x7FFFFFFF, 0x80000000.
- One natural sub-module, sign_mag: combinational two's-complement abs/negate with width parameter.
  - Used for operand magnitudes and result sign correction.
- FSM, counter and the shared 64-bit accumulator stay in sparc_muldiv_unit.

## Test plan
- UMUL rs1=0xFFFFFFFF, op2=2 -> done 34 cycles after start; result 0xFFFFFFFE, Y=0x00000001, N=1, Z=0, V=0, C=0.
- SMUL rs1=0xFFFFFFFD (−3), op2=7 -> result 0xFFFFFFEB, Y=0xFFFFFFFF, N=1.
- UDIV Y=0, rs1=100, op2=7 -> result 14, Y remains 0, V=0.
- SDIV Y=0xFFFFFFFF, rs1=0xFFFFFF9C (−100), op2=7 -> result 0xFFFFFFF2 (−14).
- UDIV Y=5, rs1=0, op2=5 -> result 0xFFFFFFFF, V=1, latency still 34.
- UDIV op2=0 -> done and div_zero pulse one cycle after start; result, Y and flags unchanged.
- Reset mid-operation: assert rst_n=0 ten cycles into a SMUL -> busy=0, Y=0, result=0, no done pulse.
- start while busy: second start ignored, single done.
- y_wr while busy: dropped.
